// File: rtl/andor_pkg.sv
// Shared types, sizes and golden function for the AND-OR sweep checker
// and any bench scoreboard that models the AND-OR unit.
package andor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;

  // vec is {a,b,c,d}; Y = A&B | C&D
  function automatic logic andor_expected(input logic [VEC_W-1:0] vec);
    return (vec[3] & vec[2]) | (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/andor_sweep_if.sv
// Bundle between the sweep checker (master) and the host/unit side (slave).
interface andor_sweep_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             d_o;
  logic             y_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       first_fail_vec;
  logic             first_fail_valid;

  modport master (
    input  start, y_i,
    output a_o, b_o, c_o, d_o, busy, done, pass, err_cnt,
           first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, y_i,
    input  a_o, b_o, c_o, d_o, busy, done, pass, err_cnt,
           first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/andor_ref_model.sv
// Combinational golden model of the AND-OR unit: vec {a,b,c,d} -> exp.
module andor_ref_model
  import andor_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp
);

  assign exp = andor_expected(vec);

endmodule

// File: rtl/andor_sweep_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into the AND-OR unit and checks Y.
// ANDOR_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module andor_sweep_checker
  import andor_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  andor_sweep_if.master bus
);

  localparam logic [4:0]       SETTLE_C = 5'(SETTLE);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_t           state_r;
  logic [VEC_W-1:0] vec_r;
  logic [4:0]       settle_cnt_r;
  logic [VEC_W-1:0] drive_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [3:0]       ff_vec_r;
  logic             ff_valid_r;

  logic             exp_s;
  logic             mismatch_s;
  logic             finish_s;
  logic [CNT_W-1:0] err_nxt_s;

  andor_ref_model u_ref (
    .vec (vec_r),
    .exp (exp_s)
  );

  // Mismatch detection, saturating count update and end-of-sweep decision
  always_comb begin
    mismatch_s = (bus.y_i != exp_s);
    if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
      err_nxt_s = err_cnt_r + CNT_W'(1);
    end else begin
      err_nxt_s = err_cnt_r;
    end
`ifdef ANDOR_STOP_ON_FAIL_EN
    finish_s = (vec_r == LAST_VEC) || mismatch_s;
`else
    finish_s = (vec_r == LAST_VEC);
`endif
  end

  // Sweep FSM with vector/settle counters and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      vec_r        <= 4'd0;
      settle_cnt_r <= 5'd0;
      drive_r      <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= '0;
      ff_vec_r     <= 4'd0;
      ff_valid_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            state_r    <= DRIVE;
            vec_r      <= 4'd0;
            err_cnt_r  <= '0;
            ff_vec_r   <= 4'd0;
            ff_valid_r <= 1'b0;
            pass_r     <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        DRIVE: begin
          drive_r      <= vec_r;
          settle_cnt_r <= 5'd0;
          state_r      <= (SETTLE_C == 5'd0) ? SAMPLE : WAIT;
        end
        WAIT: begin
          if (settle_cnt_r + 5'd1 >= SETTLE_C) begin
            state_r <= SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 5'd1;
          end
        end
        SAMPLE: begin
          err_cnt_r <= err_nxt_s;
          if (mismatch_s && !ff_valid_r) begin
            ff_vec_r   <= vec_r;
            ff_valid_r <= 1'b1;
          end
          // pass uses the count including this final sample
          if (finish_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_nxt_s == '0);
          end else begin
            vec_r   <= vec_r + 4'd1;
            state_r <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_o              = drive_r[3];
  assign bus.b_o              = drive_r[2];
  assign bus.c_o              = drive_r[1];
  assign bus.d_o              = drive_r[0];
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.pass             = pass_r;
  assign bus.err_cnt          = err_cnt_r;
  assign bus.first_fail_vec   = ff_vec_r;
  assign bus.first_fail_valid = ff_valid_r;

endmodule

// File: tb/tb_andor_sweep_checker.sv
// Directed bench: three checkers (SETTLE=1/CNT_W=5, SETTLE=1/CNT_W=2,
// SETTLE=0/CNT_W=5) share start and a selectable good/faulty AND-OR unit.
module tb_andor_sweep_checker;

  typedef struct {
    int         mode;     // 0 good, 1 stuck0, 2 stuck1, 3 a&b&c&d
    int         cyc;      // cycles to done, SETTLE=1
    int         cyc0;     // cycles to done, SETTLE=0
    logic [4:0] err5;
    logic [1:0] err2;
    logic [3:0] ffv;
    logic       ffvalid;
    logic       pass_e;
    logic [3:0] last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  int   total = 0;
  int   passed = 0;
  vec_t tbl[4];

  always #5 clk = ~clk;

  andor_sweep_if #(.CNT_W(5)) if5 ();
  andor_sweep_if #(.CNT_W(2)) if2 ();
  andor_sweep_if #(.CNT_W(5)) if0 ();

  function automatic logic unit_y(input int m, input logic a, b, c, d);
    case (m)
      0:       return (a & b) | (c & d);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a & b & c & d;
    endcase
  endfunction

  assign if5.start = start;
  assign if2.start = start;
  assign if0.start = start;
  assign if5.y_i = unit_y(mode, if5.a_o, if5.b_o, if5.c_o, if5.d_o);
  assign if2.y_i = unit_y(mode, if2.a_o, if2.b_o, if2.c_o, if2.d_o);
  assign if0.y_i = unit_y(mode, if0.a_o, if0.b_o, if0.c_o, if0.d_o);

  andor_sweep_checker #(.SETTLE(1), .CNT_W(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));
  andor_sweep_checker #(.SETTLE(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  andor_sweep_checker #(.SETTLE(0), .CNT_W(5)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {if5.a_o, if5.b_o, if5.c_o, if5.d_o, if5.busy, if5.done, if5.pass,
               if5.first_fail_valid, if5.first_fail_vec, if5.err_cnt,
               if2.busy, if2.err_cnt, if0.busy, if0.err_cnt}, 32'd0);
  endtask

  // One sweep; restart_at pulses start mid-sweep, rst_at aborts with reset
  task automatic run(input vec_t v, input int restart_at, input int rst_at);
    int busy_n, done_n, done_k5, done_k0;
    mode  = v.mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", {31'd0, if5.busy}, 32'd1);
    chk("accept_cleared", {if5.err_cnt, if5.first_fail_valid, if5.pass, if5.done}, 32'd0);
    busy_n = 1; done_n = 0; done_k5 = 0; done_k0 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == rst_at + 1 && rst_at != 0) begin
        rst = 1'b0;
        chk_zero("rst_abort_zero");
      end
      if (if5.busy) busy_n++;
      if (if5.done) begin done_n++; done_k5 = k; end
      if (if0.done) done_k0 = k;
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
      if (k == rst_at) rst = 1'b1;
    end
    if (rst_at != 0) begin
      chk("rst_no_done", done_n + done_k0, 32'd0);
      chk("rst_idle_busy", {if5.busy, if2.busy, if0.busy}, 32'd0);
    end else begin
      chk("done_count", done_n, 32'd1);
      chk("done_cycle", done_k5, v.cyc);
      chk("busy_cycles", busy_n, v.cyc);
      chk("done_cycle_settle0", done_k0, v.cyc0);
      chk("err_cnt5", if5.err_cnt, v.err5);
      chk("err_cnt_settle0", if0.err_cnt, v.err5);
      chk("err_cnt2_sat", if2.err_cnt, v.err2);
      chk("first_fail_vec", if5.first_fail_vec, v.ffv);
      chk("first_fail_valid", if5.first_fail_valid, v.ffvalid);
      chk("pass", if5.pass, v.pass_e);
      chk("held_vector", {if5.a_o, if5.b_o, if5.c_o, if5.d_o}, v.last);
    end
  endtask

  initial begin
    tbl[0] = '{mode:0, cyc:48, cyc0:32, err5:5'd0, err2:2'd0, ffv:4'd0, ffvalid:1'b0, pass_e:1'b1, last:4'hF};
`ifdef ANDOR_STOP_ON_FAIL_EN
    tbl[1] = '{mode:1, cyc:12, cyc0:8, err5:5'd1, err2:2'd1, ffv:4'd3, ffvalid:1'b1, pass_e:1'b0, last:4'h3};
    tbl[2] = '{mode:2, cyc:3,  cyc0:2, err5:5'd1, err2:2'd1, ffv:4'd0, ffvalid:1'b1, pass_e:1'b0, last:4'h0};
    tbl[3] = '{mode:3, cyc:12, cyc0:8, err5:5'd1, err2:2'd1, ffv:4'd3, ffvalid:1'b1, pass_e:1'b0, last:4'h3};
`else
    tbl[1] = '{mode:1, cyc:48, cyc0:32, err5:5'd7, err2:2'd3, ffv:4'd3, ffvalid:1'b1, pass_e:1'b0, last:4'hF};
    tbl[2] = '{mode:2, cyc:48, cyc0:32, err5:5'd9, err2:2'd3, ffv:4'd0, ffvalid:1'b1, pass_e:1'b0, last:4'hF};
    tbl[3] = '{mode:3, cyc:48, cyc0:32, err5:5'd6, err2:2'd3, ffv:4'd3, ffvalid:1'b1, pass_e:1'b0, last:4'hF};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run(tbl[i], 0, 0);
    end

    // From DONE with stale fault results: restart, with an ignored start at 10
    run(tbl[0], 10, 0);
    // Mid-sweep reset, then a clean sweep from IDLE
    run(tbl[1], 0, 20);
    run(tbl[0], 0, 0);

    // rst and start in the same cycle: reset wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk_zero("rst_beats_start");
    @(posedge clk); #1;
    chk("rst_beats_start_idle", {31'd0, if5.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/andor_sweep_checker.md
Name: andor_sweep_checker

Overview:
Sequential stimulus/response end for the 4-input AND-OR unit (Y = A&B | C&D). On a start request it drives all 16 input combinations onto the unit under check. After each vector it samples the returned Y and compares it against a golden model. It reports pass/fail, a saturating mismatch count and the first failing vector. It is used for on-chip self-check of the AND-OR unit and as a reusable bench component.

Parameters:
SETTLE, 1, cycles waited after driving a vector before Y is sampled (legal 0..15)
CNT_W, 5, width of the mismatch counter (saturating)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request sweep; accepted only in IDLE or DONE
a_o  output  1  drive to unit input A (vec[3])
b_o  output  1  drive to unit input B (vec[2])
c_o  output  1  drive to unit input C (vec[1])
d_o  output  1  drive to unit input D (vec[0])
y_i  input  1  unit output Y; combinational response to a_o..d_o
busy  output  1  high while sweep in progress
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  valid after done: 1 when err_cnt==0; held until next accepted start
err_cnt  output  CNT_W  mismatch count, saturates at 2^CNT_W-1
first_fail_vec  output  4  {a,b,c,d} of the first mismatching vector
first_fail_valid  output  1  high once any mismatch has been recorded in this sweep

Behaviour:
- Reset (rst=1 at posedge): state IDLE. vec=0, settle count=0. a_o..d_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0. Reset mid-sweep aborts immediately to these values; the partial result is lost.
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE. All outputs are registered.
- IDLE/DONE + start=1: go to DRIVE, vec=0, clear err_cnt, first_fail_*, pass. busy=1 from the next cycle.
- DRIVE (1 cycle): {a_o,b_o,c_o,d_o} <= vec. Next state is WAIT, or SAMPLE if SETTLE==0.
- WAIT: count SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle): expected = (vec[3]&vec[2])|(vec[1]&vec[0]).
  - On mismatch, err_cnt increments, saturating at its maximum.
  - On the first mismatch only, first_fail_vec=vec and first_fail_valid=1.
  - If vec==15, go to DONE. Otherwise increment vec (4-bit) and go to DRIVE.
- Cycle count: each vector takes SETTLE+2 cycles. A sweep takes 16*(SETTLE+2) cycles from the start-accept edge to entering DONE (48 for SETTLE=1).
- Entering DONE: done=1 for exactly one cycle, busy=0, pass=(err_cnt==0) using the final count. Results and the last driven vector (1111) are held.
- start while busy=1 is ignored; no restart, no queuing.
- start in DONE restarts the sweep. done does not re-pulse until the new sweep finishes.
- rst and start in the same cycle: rst wins.

Optional Feature:
ANDOR_STOP_ON_FAIL_EN
- Defined: the first mismatch in SAMPLE goes straight to DONE. done pulses, pass=0, err_cnt=1, first_fail_* are set, and the remaining vectors are skipped.
- Undefined: the full 16-vector sweep always runs, as described above.

Decomposition:
- Shared package andor_pkg holds:
  - the state enum / localparams: IDLE, DRIVE, WAIT, SAMPLE, DONE
  - NUM_VEC=16
  - VEC_W=4
  - the golden function andor_expected(vec)
- One natural sub-module, andor_ref_model: combinational golden model, vec[3:0] -> exp. It is shared with bench scoreboards.
- FSM, vector counter, settle counter and result registers all stay in andor_sweep_checker.

Test Plan:
- Correct AND-OR unit on y_i, SETTLE=1, start pulse → busy for 48 cycles, done pulse, pass=1, err_cnt=0, first_fail_valid=0.
- y_i stuck at 0 → err_cnt=7, pass=0, first_fail_vec=4'b0011, first_fail_valid=1.
- y_i stuck at 1, CNT_W=5 → err_cnt=9, first_fail_vec=4'b0000. Same fault with CNT_W=2 → err_cnt=3 (saturated).
- Faulty unit Y=A&B&C&D → err_cnt=6, first_fail_vec=4'b0011. With ANDOR_STOP_ON_FAIL_EN → done after 4*(SETTLE+2)=12 cycles, err_cnt=1.
- start re-asserted at cycle 10 of a sweep → ignored: a single done at cycle 48. Then start in DONE → results cleared and a second sweep completes 48 cycles later.
- rst asserted at cycle 20 mid-sweep → next cycle all outputs 0, state IDLE, no done pulse. A later start runs a full clean sweep.
